lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, read-modify-write for sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module lsu #(
  parameter int unsigned MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_write_control,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d, mem_wc_q, mem_wc_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_addr_q, mem_addr_d, mem_wd_q, mem_wd_d;
  logic        misalign, fault;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      2'b10:   return w;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign fault = (size_q == 2'b11) || ({2'b00, addr_q[31:2]} >= MEM_WORDS) || misalign;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = 1'b0;
    mem_wc_d    = 1'b0;
    mem_wd_d    = 32'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d        = req_we;
        uns_d       = req_unsigned;
        size_d      = req_size;
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        req_ready_d = 1'b0;
        mem_addr_d  = {req_addr[31:2], 2'b00};
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (!fault && we_q) begin
          mem_wc_d = 1'b1;
          mem_wd_d = merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
          state_d  = WRITE;
        end else begin
          // loads resolve here; data is taken straight from the memory word
          mem_addr_d  = 32'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = fault;
          rsp_rdata_d = (fault || we_q) ? 32'b0 : load_ext(mem_rdata, size_q, uns_q, addr_q[1:0]);
          state_d     = RESP;
        end
      end
      WRITE: begin
        mem_addr_d  = 32'b0;
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 32'b0;
        state_d     = RESP;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      mem_wc_q    <= 1'b0;
      mem_addr_q  <= 32'b0;
      mem_wd_q    <= 32'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_wc_q    <= mem_wc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_fault         = rsp_fault_q;
  assign mem_write_control = mem_wc_q;
  assign mem_addr          = mem_addr_q;
  assign mem_write_data    = mem_wd_q;

endmodule
